// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state, opcode and select-line encodings for the multicycle control unit.
// MC_CTRL_HALT_EN makes opcode 1111 a legal halt instead of an illegal opcode.
package mc_ctrl_pkg;
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;
    localparam logic [3:0] OP_R = 4'h0, OP_ADDI = 4'h1, OP_ORI = 4'h2, OP_LW = 4'h3;
    localparam logic [3:0] OP_SW = 4'h4, OP_BEQ = 4'h5, OP_JMP = 4'h6, OP_HALT = 4'hf;
    localparam logic SRCA_PC = 1'b0, SRCA_REG = 1'b1;
    localparam logic [2:0] SRCB_REG2 = 3'b000, SRCB_ONE = 3'b001, SRCB_IMM = 3'b010;
    localparam logic [2:0] SRCB_SHL = 3'b011, SRCB_JMP = 3'b100;
    localparam logic [1:0] RD1_RT = 2'b00, RD1_BT = 2'b01, RD1_BASE = 2'b10;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_OR = 3'b010, ALU_FUNCT = 3'b111;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_HOLD = 2'b10;
    typedef struct packed {
        logic       alusrc_a;
        logic [2:0] alusrc_b;
        logic [1:0] read1r;
        logic       read2r;
        logic       sign_ext;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       pc_write;
        logic       pc_write_cond;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
    } ctrl_t;
    function automatic logic legal_op(input logic [3:0] op);
`ifdef MC_CTRL_HALT_EN
        return op <= OP_JMP || op == OP_HALT;
`else
        return op <= OP_JMP;
`endif
    endfunction
endpackage

// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control unit <-> datapath bundle; master is the control unit driving select lines.
interface mc_ctrl_if;
    logic [3:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    logic       C_ALUSrc_A;
    logic [2:0] C_ALUSrc_B;
    logic [1:0] C_RegDstRead1R;
    logic       C_RegDstRead2R;
    logic       C_SignExtend;
    logic [2:0] C_ALUOp;
    logic [1:0] C_PCSource;
    logic       C_PCWrite, C_PCWriteCond, C_IRWrite, C_MemRead, C_MemWrite, C_RegWrite, C_MemToReg;
    modport master (
        input  opcode, mem_ready, alu_zero,
        output C_ALUSrc_A, C_ALUSrc_B, C_RegDstRead1R, C_RegDstRead2R, C_SignExtend, C_ALUOp,
               C_PCSource, C_PCWrite, C_PCWriteCond, C_IRWrite, C_MemRead, C_MemWrite,
               C_RegWrite, C_MemToReg
    );
    modport slave (
        output opcode, mem_ready, alu_zero,
        input  C_ALUSrc_A, C_ALUSrc_B, C_RegDstRead1R, C_RegDstRead2R, C_SignExtend, C_ALUOp,
               C_PCSource, C_PCWrite, C_PCWriteCond, C_IRWrite, C_MemRead, C_MemWrite,
               C_RegWrite, C_MemToReg
    );
endinterface

// File: rtl/mc_ctrl_decode.sv
// mc_ctrl_decode: combinational state -> datapath control decoder; reset forces everything low.
module mc_ctrl_decode
    import mc_ctrl_pkg::*;
(
    input  logic       reset,
    input  state_t     state,
    input  logic [3:0] opcode,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output logic       illegal_op
);
    always_comb begin
        ctrl = '0;
        ctrl.pc_source = PCS_HOLD;
        case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.alusrc_b = SRCB_ONE;
                ctrl.pc_source = PCS_ALU;
                ctrl.ir_write = mem_ready;
                ctrl.pc_write = mem_ready;
            end
            S_DECODE: ctrl.alusrc_b = SRCB_SHL;
            S_EXEC_R: begin
                ctrl.alusrc_a = SRCA_REG;
                ctrl.alu_op = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.alusrc_a = SRCA_REG;
                ctrl.alusrc_b = SRCB_IMM;
                ctrl.sign_ext = opcode == OP_ADDI;
                ctrl.alu_op = opcode == OP_ADDI ? ALU_ADD : ALU_OR;
            end
            S_WB_ALU: ctrl.reg_write = 1'b1;
            S_MEM_ADDR: begin
                ctrl.alusrc_a = SRCA_REG;
                ctrl.read1r = RD1_BASE;
                ctrl.alusrc_b = SRCB_IMM;
                ctrl.sign_ext = 1'b1;
            end
            S_MEM_RD: ctrl.mem_read = 1'b1;
            S_MEM_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.read2r = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alusrc_a = SRCA_REG;
                ctrl.read1r = RD1_BT;
                ctrl.alu_op = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source = PCS_ALUOUT;
            end
            S_JUMP: begin
                ctrl.alusrc_b = SRCB_JMP;
                ctrl.pc_write = 1'b1;
                ctrl.pc_source = PCS_ALU;
            end
            default: ;
        endcase
        if (reset) ctrl = '0;
    end
    assign illegal_op = !reset && state == S_DECODE && !legal_op(opcode);
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multicycle control FSM (state register + next-state logic) for the 16-bit CPU.
// Define MC_CTRL_HALT_EN to make opcode 1111 enter a HALT state held until reset.
module mc_control_fsm
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    mc_ctrl_if.master  bus,
    output logic       illegal_op,
    output logic [3:0] state_o
);
    state_t state, nxt;
    ctrl_t  ctrl;
    always_ff @(posedge clk) state <= reset ? S_FETCH : nxt;
    always_comb begin
        nxt = state;
        case (state)
            S_FETCH: nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE:
                case (bus.opcode)
                    OP_R:            nxt = S_EXEC_R;
                    OP_ADDI, OP_ORI: nxt = S_EXEC_I;
                    OP_LW, OP_SW:    nxt = S_MEM_ADDR;
                    OP_BEQ:          nxt = S_BRANCH;
                    OP_JMP:          nxt = S_JUMP;
`ifdef MC_CTRL_HALT_EN
                    OP_HALT:         nxt = S_HALT;
`endif
                    default:         nxt = S_FETCH;
                endcase
            S_EXEC_R, S_EXEC_I: nxt = S_WB_ALU;
            S_MEM_ADDR: nxt = bus.opcode == OP_LW ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: nxt = bus.mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR: nxt = bus.mem_ready ? S_FETCH : S_MEM_WR;
            S_HALT: nxt = S_HALT;
            default: nxt = S_FETCH;
        endcase
    end
    mc_ctrl_decode u_decode (
        .reset      (reset),
        .state      (state),
        .opcode     (bus.opcode),
        .mem_ready  (bus.mem_ready),
        .ctrl       (ctrl),
        .illegal_op (illegal_op)
    );
    assign bus.C_ALUSrc_A     = ctrl.alusrc_a;
    assign bus.C_ALUSrc_B     = ctrl.alusrc_b;
    assign bus.C_RegDstRead1R = ctrl.read1r;
    assign bus.C_RegDstRead2R = ctrl.read2r;
    assign bus.C_SignExtend   = ctrl.sign_ext;
    assign bus.C_ALUOp        = ctrl.alu_op;
    assign bus.C_PCSource     = ctrl.pc_source;
    assign bus.C_PCWrite      = ctrl.pc_write;
    assign bus.C_PCWriteCond  = ctrl.pc_write_cond;
    assign bus.C_IRWrite      = ctrl.ir_write;
    assign bus.C_MemRead      = ctrl.mem_read;
    assign bus.C_MemWrite     = ctrl.mem_write;
    assign bus.C_RegWrite     = ctrl.reg_write;
    assign bus.C_MemToReg     = ctrl.mem_to_reg;
    assign state_o = reset ? S_FETCH : state;
endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: random instruction stream against a per-instruction phase model; a monitor
// pops one expected control vector per cycle from a scoreboard queue.
module tb_mc_control_fsm;
    import mc_ctrl_pkg::*;
`ifdef MC_CTRL_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    typedef struct packed {
        logic       a;
        logic [2:0] b;
        logic [1:0] r1;
        logic       r2;
        logic       se;
        logic [2:0] op;
        logic [1:0] pcs;
        logic       pcw, pcwc, irw, mr, mw, rw, m2r, ill;
        logic [3:0] st;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic illegal_op;
    logic [3:0] state_o;
    logic [3:0] cur_op = 4'h0;
    exp_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle = 0;
    mc_ctrl_if bus ();
    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .illegal_op (illegal_op),
        .state_o    (state_o)
    );
    always #5 clk = ~clk;
    function automatic logic rnd();
        return $urandom_range(0, 1) == 1;
    endfunction
    function automatic exp_t idle(input state_t s);
        exp_t e = '0;
        e.pcs = 2'b10;
        e.st = s;
        return e;
    endfunction
    function automatic exp_t fetch(input logic ready);
        exp_t e = idle(S_FETCH);
        e.mr = 1'b1;
        e.b = 3'b001;
        e.pcs = 2'b00;
        e.irw = ready;
        e.pcw = ready;
        return e;
    endfunction
    task automatic cyc(input logic mr, input logic rs, input exp_t e);
        @(negedge clk);
        bus.opcode = cur_op;
        bus.mem_ready = mr;
        bus.alu_zero = rnd();
        reset = rs;
        exp_q.push_back(e);
    endtask
    // One instruction: fs fetch stalls, ms memory stalls, abort = reset during the memory phase
    task automatic instr(input logic [3:0] op, input int fs, input int ms, input bit abort);
        exp_t e;
        bit ok;
        ok = op <= 4'd6 || (HALT_EN && op == 4'hf);
        cur_op = op;
        for (int i = 0; i < fs; i++) cyc(1'b0, 1'b0, fetch(1'b0));
        cyc(1'b1, 1'b0, fetch(1'b1));
        e = idle(S_DECODE);
        e.b = 3'b011;
        e.ill = !ok;
        cyc(rnd(), 1'b0, e);
        if (!ok) return;
        case (op)
            4'd0, 4'd1, 4'd2: begin
                e = idle(op == 4'd0 ? S_EXEC_R : S_EXEC_I);
                e.a = 1'b1;
                e.b = op == 4'd0 ? 3'b000 : 3'b010;
                e.op = op == 4'd0 ? 3'b111 : op == 4'd1 ? 3'b000 : 3'b010;
                e.se = op == 4'd1;
                cyc(rnd(), 1'b0, e);
                e = idle(S_WB_ALU);
                e.rw = 1'b1;
                cyc(rnd(), 1'b0, e);
            end
            4'd3, 4'd4: begin
                e = idle(S_MEM_ADDR);
                e.a = 1'b1;
                e.r1 = 2'b10;
                e.b = 3'b010;
                e.se = 1'b1;
                cyc(rnd(), 1'b0, e);
                e = idle(op == 4'd3 ? S_MEM_RD : S_MEM_WR);
                e.mr = op == 4'd3;
                e.mw = op == 4'd4;
                e.r2 = op == 4'd4;
                for (int i = 0; i < ms; i++) cyc(1'b0, 1'b0, e);
                if (abort) begin
                    cyc(rnd(), 1'b1, '0);
                    return;
                end
                cyc(1'b1, 1'b0, e);
                if (op == 4'd3) begin
                    e = idle(S_MEM_WB);
                    e.rw = 1'b1;
                    e.m2r = 1'b1;
                    cyc(rnd(), 1'b0, e);
                end
            end
            4'd5: begin
                e = idle(S_BRANCH);
                e.a = 1'b1;
                e.r1 = 2'b01;
                e.op = 3'b001;
                e.pcwc = 1'b1;
                e.pcs = 2'b01;
                cyc(rnd(), 1'b0, e);
            end
            4'd6: begin
                e = idle(S_JUMP);
                e.b = 3'b100;
                e.pcw = 1'b1;
                e.pcs = 2'b00;
                cyc(rnd(), 1'b0, e);
            end
            default: begin
                repeat (20) cyc(rnd(), 1'b0, idle(S_HALT));
                cyc(rnd(), 1'b1, '0);
            end
        endcase
    endtask
    initial begin
        exp_t e, act;
        forever begin
            @(negedge clk);
            #2;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                act = {bus.C_ALUSrc_A, bus.C_ALUSrc_B, bus.C_RegDstRead1R, bus.C_RegDstRead2R,
                       bus.C_SignExtend, bus.C_ALUOp, bus.C_PCSource, bus.C_PCWrite,
                       bus.C_PCWriteCond, bus.C_IRWrite, bus.C_MemRead, bus.C_MemWrite,
                       bus.C_RegWrite, bus.C_MemToReg, illegal_op, state_o};
                checks++;
                if (act !== e) begin
                    errors++;
                    $display("FAIL ctrl cycle=%0d got=%h want=%h (state got=%0d want=%0d)",
                             cycle, act, e, act.st, e.st);
                end
            end
        end
    end
    initial begin
        bus.opcode = 4'h0;
        bus.mem_ready = 1'b0;
        bus.alu_zero = 1'b0;
        repeat (3) cyc(rnd(), 1'b1, '0);
        instr(4'h0, 0, 0, 1'b0);
        instr(4'h3, 0, 2, 1'b0);
        instr(4'h5, 0, 0, 1'b0);
        instr(4'h5, 1, 0, 1'b0);
        instr(4'ha, 0, 0, 1'b0);
        instr(4'h4, 1, 2, 1'b1);
        instr(4'h4, 0, 1, 1'b0);
        instr(4'hf, 0, 0, 1'b0);
        instr(4'h1, 0, 0, 1'b0);
        instr(4'h2, 2, 0, 1'b0);
        instr(4'h6, 0, 0, 1'b0);
        instr(4'h3, 0, 0, 1'b1);
        for (int n = 0; n < 80; n++)
            instr($urandom_range(0, 3) == 0 ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6)),
                  $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 2) == 0 ? $urandom_range(1, 3) : 0,
                  $urandom_range(0, 9) == 0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
